// File: rtl/dogx_channel_sequencer_if.sv
// Request and status bundle between the alpha generator side and the HSNR/HDR channel sequencer.
// The master drives the run, request and timing controls; the slave returns the channel enables and status.
interface dogx_channel_sequencer_if #(
    parameter int WARMUP_W = 8,
    parameter int HOLD_W   = 8
);
    logic                enable;
    logic                alpha_req;
    logic [WARMUP_W-1:0] warmup_cycles;
    logic [HOLD_W-1:0]   hold_cycles;
    logic                keep_both_on;
    logic                enable_HSNR;
    logic                enable_HDR;
    logic                alpha_sel;
    logic                busy;
    logic [15:0]         switch_count;

    modport master (
        output enable,
        output alpha_req,
        output warmup_cycles,
        output hold_cycles,
        output keep_both_on,
        input  enable_HSNR,
        input  enable_HDR,
        input  alpha_sel,
        input  busy,
        input  switch_count
    );

    modport slave (
        input  enable,
        input  alpha_req,
        input  warmup_cycles,
        input  hold_cycles,
        input  keep_both_on,
        output enable_HSNR,
        output enable_HDR,
        output alpha_sel,
        output busy,
        output switch_count
    );
endinterface

// File: rtl/dogx_channel_sequencer.sv
// Sequences the HSNR/HDR channel pair of the DOGX converter: warm up the target channel,
// flip alpha_sel, overlap both channels for a hold time, then gate off the idle one.
module dogx_channel_sequencer #(
    parameter int WARMUP_W = 8,
    parameter int HOLD_W   = 8
) (
    input  logic                    CLK_3M,
    input  logic                    reset,
    dogx_channel_sequencer_if.slave bus
);

    localparam int   CNT_W            = (WARMUP_W > HOLD_W) ? WARMUP_W : HOLD_W;
    localparam logic ALPHA_SELECT_HDR = 1'b1;
    localparam logic ALPHA_SELECT_HSNR = 1'b0;

    typedef enum logic [2:0] {
        S_OFF,
        S_START,
        S_RUN_HSNR,
        S_WARM_HDR,
        S_HOLD_HDR,
        S_RUN_HDR,
        S_WARM_HSNR,
        S_HOLD_HSNR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_en_hsnr;
    logic              w_en_hsnr_nxt;
    logic              r_en_hdr;
    logic              w_en_hdr_nxt;
    logic              r_alpha_sel;
    logic              w_alpha_sel_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic [15:0]       r_switch_count;
    logic [15:0]       w_switch_count_nxt;

    logic              w_cnt_zero;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic [CNT_W-1:0]  w_warmup_load;
    logic [CNT_W-1:0]  w_hold_load;
    logic [15:0]       w_switch_inc;

    assign w_cnt_zero    = (r_cnt == '0);
    assign w_cnt_dec     = r_cnt - CNT_W'(1);
    assign w_warmup_load = CNT_W'(bus.warmup_cycles);
    assign w_hold_load   = CNT_W'(bus.hold_cycles);
    // The flip counter sticks at all-ones instead of wrapping.
    assign w_switch_inc  = (r_switch_count == 16'hFFFF) ? r_switch_count : r_switch_count + 16'd1;

    // NOTE: every next-state signal takes its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_en_hsnr_nxt      = r_en_hsnr;
        w_en_hdr_nxt       = r_en_hdr;
        w_alpha_sel_nxt    = r_alpha_sel;
        w_switch_count_nxt = r_switch_count;

        if (!bus.enable) begin
            w_state_nxt     = S_OFF;
            w_cnt_nxt       = '0;
            w_en_hsnr_nxt   = 1'b0;
            w_en_hdr_nxt    = 1'b0;
            w_alpha_sel_nxt = ALPHA_SELECT_HSNR;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt   = S_START;
                    w_en_hsnr_nxt = 1'b1;
                    w_cnt_nxt     = w_warmup_load;
                end

                S_START: begin
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = w_cnt_dec;
                    end else begin
                        w_state_nxt = S_RUN_HSNR;
                    end
                end

                S_RUN_HSNR: begin
                    w_en_hsnr_nxt = 1'b1;
                    w_en_hdr_nxt  = bus.keep_both_on;
                    if (bus.alpha_req == ALPHA_SELECT_HDR) begin
                        w_state_nxt  = S_WARM_HDR;
                        w_en_hdr_nxt = 1'b1;
                        w_cnt_nxt    = w_warmup_load;
                    end
                end

                S_WARM_HDR: begin
                    // A withdrawn request wins over an expiring warm-up in the same cycle.
                    if (bus.alpha_req == ALPHA_SELECT_HSNR) begin
                        w_state_nxt  = S_RUN_HSNR;
                        w_en_hdr_nxt = bus.keep_both_on;
                    end else if (!w_cnt_zero) begin
                        w_cnt_nxt = w_cnt_dec;
                    end else begin
                        w_state_nxt        = S_HOLD_HDR;
                        w_alpha_sel_nxt    = ALPHA_SELECT_HDR;
                        w_cnt_nxt          = w_hold_load;
                        w_switch_count_nxt = w_switch_inc;
                    end
                end

                S_HOLD_HDR: begin
                    w_en_hsnr_nxt = 1'b1;
                    w_en_hdr_nxt  = 1'b1;
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = w_cnt_dec;
                    end else begin
                        w_state_nxt   = S_RUN_HDR;
                        w_en_hsnr_nxt = bus.keep_both_on;
                    end
                end

                S_RUN_HDR: begin
                    w_en_hdr_nxt  = 1'b1;
                    w_en_hsnr_nxt = bus.keep_both_on;
                    if (bus.alpha_req == ALPHA_SELECT_HSNR) begin
                        w_state_nxt   = S_WARM_HSNR;
                        w_en_hsnr_nxt = 1'b1;
                        w_cnt_nxt     = w_warmup_load;
                    end
                end

                S_WARM_HSNR: begin
                    if (bus.alpha_req == ALPHA_SELECT_HDR) begin
                        w_state_nxt   = S_RUN_HDR;
                        w_en_hsnr_nxt = bus.keep_both_on;
                    end else if (!w_cnt_zero) begin
                        w_cnt_nxt = w_cnt_dec;
                    end else begin
                        w_state_nxt        = S_HOLD_HSNR;
                        w_alpha_sel_nxt    = ALPHA_SELECT_HSNR;
                        w_cnt_nxt          = w_hold_load;
                        w_switch_count_nxt = w_switch_inc;
                    end
                end

                S_HOLD_HSNR: begin
                    w_en_hsnr_nxt = 1'b1;
                    w_en_hdr_nxt  = 1'b1;
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = w_cnt_dec;
                    end else begin
                        w_state_nxt  = S_RUN_HSNR;
                        w_en_hdr_nxt = bus.keep_both_on;
                    end
                end

                default: begin
                    w_state_nxt     = S_OFF;
                    w_cnt_nxt       = '0;
                    w_en_hsnr_nxt   = 1'b0;
                    w_en_hdr_nxt    = 1'b0;
                    w_alpha_sel_nxt = ALPHA_SELECT_HSNR;
                end
            endcase
        end

        // busy is registered from the state being entered so it lines up with that state.
        w_busy_nxt = (w_state_nxt == S_START)     ||
                     (w_state_nxt == S_WARM_HDR)  || (w_state_nxt == S_HOLD_HDR) ||
                     (w_state_nxt == S_WARM_HSNR) || (w_state_nxt == S_HOLD_HSNR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_3M or posedge reset) begin
        if (reset) begin
            r_state        <= S_OFF;
            r_cnt          <= '0;
            r_en_hsnr      <= 1'b0;
            r_en_hdr       <= 1'b0;
            r_alpha_sel    <= ALPHA_SELECT_HSNR;
            r_busy         <= 1'b0;
            r_switch_count <= 16'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_en_hsnr      <= w_en_hsnr_nxt;
            r_en_hdr       <= w_en_hdr_nxt;
            r_alpha_sel    <= w_alpha_sel_nxt;
            r_busy         <= w_busy_nxt;
            r_switch_count <= w_switch_count_nxt;
        end
    end

    assign bus.enable_HSNR  = r_en_hsnr;
    assign bus.enable_HDR   = r_en_hdr;
    assign bus.alpha_sel    = r_alpha_sel;
    assign bus.busy         = r_busy;
    assign bus.switch_count = r_switch_count;

endmodule

// File: tb/tb_dogx_channel_sequencer.sv
// Directed bench for dogx_channel_sequencer: stimulus queues the expected output changes with
// their cycle numbers, and a negedge monitor pops and compares each change the DUT shows.
module tb_dogx_channel_sequencer;

    logic CLK_3M;
    logic reset;

    dogx_channel_sequencer_if #(.WARMUP_W(8), .HOLD_W(8)) bus ();

    dogx_channel_sequencer #(.WARMUP_W(8), .HOLD_W(8)) dut (
        .CLK_3M (CLK_3M),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        logic [19:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [19:0] w_obs;
    logic [19:0] r_prev;

    // Observed vector: {enable_HSNR, enable_HDR, alpha_sel, busy, switch_count}.
    assign w_obs = {bus.enable_HSNR, bus.enable_HDR, bus.alpha_sel, bus.busy, bus.switch_count};

    initial begin
        CLK_3M = 1'b0;
        forever #5 CLK_3M = ~CLK_3M;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK_3M);
            cyc = cyc + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d events pending", sb_q.size());
        $fatal(1, "watchdog timeout");
    end

    function automatic logic [19:0] o(input bit hsnr, input bit hdr, input bit sel,
                                      input bit bsy, input logic [15:0] sc);
        return {hsnr, hdr, sel, bsy, sc};
    endfunction

    task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got cyc=%0d out=%h, expected cyc=%0d out=%h",
                     name, act[51:20], act[19:0], exp[51:20], exp[19:0]);
        end
    endtask

    task automatic push(input int at, input logic [19:0] v);
        exp_t e;
        e.cyc = at;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge CLK_3M);
    endtask

    // Monitor: every visible output change must match the next queued event, value and cycle.
    initial begin
        exp_t e;
        r_prev = '0;
        forever begin
            @(negedge CLK_3M);
            if (w_obs !== r_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_change", {32'(cyc), w_obs}, {32'(cyc), r_prev});
                end else begin
                    e = sb_q.pop_front();
                    check("output_event", {32'(cyc), w_obs}, {32'(e.cyc), e.val});
                end
                r_prev = w_obs;
            end
        end
    end

    initial begin
        int t;
        n_checks = 0;
        n_fail   = 0;
        reset             = 1'b1;
        bus.enable        = 1'b0;
        bus.alpha_req     = 1'b0;
        bus.warmup_cycles = 8'd3;
        bus.hold_cycles   = 8'd2;
        bus.keep_both_on  = 1'b0;
        repeat (2) tick();
        check("reset_state", {32'd0, w_obs}, {32'd0, 20'h0});
        reset = 1'b0;
        tick();

        // Start-up: HSNR on, busy for warmup+1 cycles, then RUN_HSNR.
        bus.enable = 1'b1;
        t = cyc + 1;
        push(t,     o(1, 0, 0, 1, 16'd0));
        push(t + 4, o(1, 0, 0, 0, 16'd0));
        repeat (6) tick();

        // Request withdrawn exactly when the warm-up counter has reached zero: abort.
        bus.alpha_req = 1'b1;
        t = cyc + 1;
        push(t,     o(1, 1, 0, 1, 16'd0));
        push(t + 4, o(1, 0, 0, 0, 16'd0));
        repeat (4) tick();
        bus.alpha_req = 1'b0;
        repeat (3) tick();

        // Full HSNR->HDR switch, request glitches during HOLD ignored, then back to HSNR.
        bus.alpha_req = 1'b1;
        t = cyc + 1;
        push(t,      o(1, 1, 0, 1, 16'd0));
        push(t + 4,  o(1, 1, 1, 1, 16'd1));
        push(t + 7,  o(0, 1, 1, 0, 16'd1));
        push(t + 8,  o(1, 1, 1, 1, 16'd1));
        push(t + 12, o(1, 1, 0, 1, 16'd2));
        push(t + 15, o(1, 0, 0, 0, 16'd2));
        repeat (5) tick();
        bus.alpha_req = 1'b0;
        tick();
        bus.alpha_req = 1'b1;
        tick();
        bus.alpha_req = 1'b0;
        repeat (2) tick();
        bus.warmup_cycles = 8'd7;
        repeat (8) tick();

        // keep_both_on with zero-length warm-up and hold: one cycle per phase, both stay on.
        bus.warmup_cycles = 8'd0;
        bus.hold_cycles   = 8'd0;
        bus.keep_both_on  = 1'b1;
        t = cyc + 1;
        push(t,     o(1, 1, 0, 0, 16'd2));
        push(t + 1, o(1, 1, 0, 1, 16'd2));
        push(t + 2, o(1, 1, 1, 1, 16'd3));
        push(t + 3, o(1, 1, 1, 0, 16'd3));
        push(t + 4, o(1, 1, 1, 1, 16'd3));
        push(t + 5, o(1, 1, 0, 1, 16'd4));
        push(t + 6, o(1, 1, 0, 0, 16'd4));
        push(t + 7, o(1, 0, 0, 0, 16'd4));
        tick();
        bus.alpha_req = 1'b1;
        repeat (3) tick();
        bus.alpha_req = 1'b0;
        repeat (3) tick();
        bus.keep_both_on = 1'b0;
        repeat (2) tick();

        // enable dropped mid-WARM: OFF next edge, switch_count kept, then a fresh start.
        bus.warmup_cycles = 8'd3;
        bus.hold_cycles   = 8'd2;
        bus.alpha_req     = 1'b1;
        t = cyc + 1;
        push(t,     o(1, 1, 0, 1, 16'd4));
        push(t + 2, o(0, 0, 0, 0, 16'd4));
        push(t + 3, o(1, 0, 0, 1, 16'd4));
        push(t + 7, o(1, 0, 0, 0, 16'd4));
        repeat (2) tick();
        bus.enable    = 1'b0;
        bus.alpha_req = 1'b0;
        tick();
        bus.enable = 1'b1;
        repeat (6) tick();

        // Reset pulsed mid-HOLD: outputs clear at once, switch_count included.
        bus.warmup_cycles = 8'd0;
        bus.hold_cycles   = 8'd3;
        bus.alpha_req     = 1'b1;
        t = cyc + 1;
        push(t,     o(1, 1, 0, 1, 16'd4));
        push(t + 1, o(1, 1, 1, 1, 16'd5));
        push(t + 3, o(0, 0, 0, 0, 16'd0));
        repeat (3) tick();
        #2 reset = 1'b1;
        #1 check("async_reset", {32'd0, w_obs}, {32'd0, 20'h0});
        tick();
        reset             = 1'b0;
        bus.alpha_req     = 1'b0;
        bus.warmup_cycles = 8'd3;
        bus.hold_cycles   = 8'd2;
        t = cyc + 1;
        push(t,     o(1, 0, 0, 1, 16'd0));
        push(t + 4, o(1, 0, 0, 0, 16'd0));
        repeat (6) tick();

        // Saturation: preload the flip counter one short of full, then flip twice.
        push(cyc + 1, o(1, 0, 0, 0, 16'hFFFE));
        #2 force dut.r_switch_count = 16'hFFFE;
        #1 release dut.r_switch_count;
        tick();
        bus.warmup_cycles = 8'd0;
        bus.hold_cycles   = 8'd0;
        bus.alpha_req     = 1'b1;
        t = cyc + 1;
        push(t,     o(1, 1, 0, 1, 16'hFFFE));
        push(t + 1, o(1, 1, 1, 1, 16'hFFFF));
        push(t + 2, o(0, 1, 1, 0, 16'hFFFF));
        push(t + 3, o(1, 1, 1, 1, 16'hFFFF));
        push(t + 4, o(1, 1, 0, 1, 16'hFFFF));
        push(t + 5, o(1, 0, 0, 0, 16'hFFFF));
        repeat (3) tick();
        bus.alpha_req = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check("scoreboard_drained", {32'(sb_q.size()), 20'h0}, {32'd0, 20'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
